// File: rtl/figure_sequencer.sv
// figure_sequencer: frame-synchronous scheduler for the figure-drawing stage.
// Once per frame, at HCount==0 / VCount==V_ACTIVE (inside vertical blanking),
// it updates figure select, position and blank, so changes never tear a frame.
// Button edges are synchronised and queued until the next frame tick.
// Optional feature macro: FIGSEQ_AUTO_ADVANCE_EN (hold counter, auto-advance).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_BLANK | screen forced black, position/selection frozen
// ST_SHOW  | figure visible, bouncing by STEP per frame
// ST_PAUSE | figure visible, position and hold frozen, next still works
module figure_sequencer #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned FIG_W       = 32,
  parameter int unsigned FIG_H       = 32,
  parameter int unsigned STEP        = 2,
  parameter int unsigned HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] HCount,
  input  logic [9:0] VCount,
  input  logic       btn_next,
  input  logic       btn_pause,
  output logic [1:0] fig_sel,
  output logic [9:0] fig_x,
  output logic [9:0] fig_y,
  output logic       blank,
  output logic       frame_tick
);

  localparam logic [9:0] XMAX  = 10'(H_ACTIVE - FIG_W);
  localparam logic [9:0] YMAX  = 10'(V_ACTIVE - FIG_H);
  localparam logic [9:0] X_RST = XMAX / 10'd2;
  localparam logic [9:0] Y_RST = YMAX / 10'd2;

  typedef enum logic [1:0] {ST_BLANK, ST_SHOW, ST_PAUSE} state_t;

  state_t     state_q, state_d;
  logic [1:0] next_sync_q, pause_sync_q;
  logic       next_prev_q, pause_prev_q;
  logic       next_pend_q, next_pend_d;
  logic       pause_pend_q, pause_pend_d;
  logic [1:0] sel_q, sel_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic       blank_q, blank_d;
  logic       tick_q;
  logic       tick, next_edge, pause_edge, auto_adv;
  logic [10:0] bx, by;

  // Returns {direction_up, position} after one bounce step against [0, lim].
  function automatic logic [10:0] bounce(input logic [9:0] pos, input logic up,
                                         input logic [9:0] lim);
    logic [10:0] sum;
    sum = {1'b0, pos} + 11'(STEP);
    if (up) begin
      if (sum >= {1'b0, lim}) return {1'b0, lim};
      else                    return {1'b1, pos + 10'(STEP)};
    end else begin
      if (pos <= 10'(STEP))   return {1'b1, 10'd0};
      else                    return {1'b0, pos - 10'(STEP)};
    end
  endfunction

  assign tick       = (HCount == 10'd0) && (VCount == 10'(V_ACTIVE));
  assign next_edge  = next_sync_q[1] & ~next_prev_q;
  assign pause_edge = pause_sync_q[1] & ~pause_prev_q;
  assign bx         = bounce(x_q, dir_x_q, XMAX);
  assign by         = bounce(y_q, dir_y_q, YMAX);

`ifdef FIGSEQ_AUTO_ADVANCE_EN
  localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  logic [HOLD_W-1:0] hold_q, hold_d;
  assign auto_adv = (hold_q == HOLD_W'(HOLD_FRAMES - 1));
`else
  // Hold length has no meaning without the counter.
  localparam int unsigned hold_frames_unused = HOLD_FRAMES;
  assign auto_adv = 1'b0;
`endif

  // Next-state: queue button edges, act on them only at the frame tick.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    // An edge coinciding with the tick survives for the following frame.
    next_pend_d  = (tick ? 1'b0 : next_pend_q) | next_edge;
    pause_pend_d = (tick ? 1'b0 : pause_pend_q) | pause_edge;
`ifdef FIGSEQ_AUTO_ADVANCE_EN
    hold_d       = hold_q;
`endif
    if (tick) begin
      case (state_q)
        ST_BLANK: begin
          if (next_pend_q) begin
            state_d = ST_SHOW;
            sel_d   = 2'd0;
`ifdef FIGSEQ_AUTO_ADVANCE_EN
            hold_d  = '0;
`endif
          end
        end
        ST_SHOW: begin
          if (pause_pend_q) begin
            state_d = ST_PAUSE;
          end else begin
            {dir_x_d, x_d} = bx;
            {dir_y_d, y_d} = by;
`ifdef FIGSEQ_AUTO_ADVANCE_EN
            hold_d = hold_q + 1'b1;
`endif
          end
          if (next_pend_q || auto_adv) begin
            sel_d = sel_q + 2'd1;
`ifdef FIGSEQ_AUTO_ADVANCE_EN
            hold_d = '0;
`endif
          end
        end
        ST_PAUSE: begin
          if (pause_pend_q) state_d = ST_SHOW;
          if (next_pend_q) begin
            sel_d = sel_q + 2'd1;
`ifdef FIGSEQ_AUTO_ADVANCE_EN
            hold_d = '0;
`endif
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end
    blank_d = (state_d == ST_BLANK);
  end

  // State, synchronisers and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_BLANK;
      next_sync_q  <= 2'b00;
      pause_sync_q <= 2'b00;
      next_prev_q  <= 1'b0;
      pause_prev_q <= 1'b0;
      next_pend_q  <= 1'b0;
      pause_pend_q <= 1'b0;
      sel_q        <= 2'd0;
      x_q          <= X_RST;
      y_q          <= Y_RST;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      blank_q      <= 1'b1;
      tick_q       <= 1'b0;
`ifdef FIGSEQ_AUTO_ADVANCE_EN
      hold_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      next_sync_q  <= {next_sync_q[0], btn_next};
      pause_sync_q <= {pause_sync_q[0], btn_pause};
      next_prev_q  <= next_sync_q[1];
      pause_prev_q <= pause_sync_q[1];
      next_pend_q  <= next_pend_d;
      pause_pend_q <= pause_pend_d;
      sel_q        <= sel_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      blank_q      <= blank_d;
      tick_q       <= tick;
`ifdef FIGSEQ_AUTO_ADVANCE_EN
      hold_q       <= hold_d;
`endif
    end
  end

  assign fig_sel    = sel_q;
  assign fig_x      = x_q;
  assign fig_y      = y_q;
  assign blank      = blank_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_figure_sequencer.sv
// Directed bench for figure_sequencer: a table of button/tick steps with
// hand-computed outputs, plus sequences for tick timing, reset and auto-advance.
module tb_figure_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] HCount, VCount;
  logic       btn_next, btn_pause, a_next, a_pause;
  logic [1:0] fig_sel, a_sel;
  logic [9:0] fig_x, fig_y, a_x, a_y;
  logic       blank, frame_tick, a_blank, a_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  figure_sequencer #(.HOLD_FRAMES(1000)) dut (
    .clk(clk), .rst(rst), .HCount(HCount), .VCount(VCount),
    .btn_next(btn_next), .btn_pause(btn_pause),
    .fig_sel(fig_sel), .fig_x(fig_x), .fig_y(fig_y),
    .blank(blank), .frame_tick(frame_tick)
  );

  figure_sequencer #(.HOLD_FRAMES(4)) dut_auto (
    .clk(clk), .rst(rst), .HCount(HCount), .VCount(VCount),
    .btn_next(a_next), .btn_pause(a_pause),
    .fig_sel(a_sel), .fig_x(a_x), .fig_y(a_y),
    .blank(a_blank), .frame_tick(a_tick)
  );

  typedef struct {
    int nn;   // btn_next pulses before the ticks
    int np;   // btn_pause pulses before the ticks
    int nt;   // frame ticks
    int sel;
    int x;
    int y;
    int blk;
  } vec_t;

  vec_t vt[23];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One match cycle; returns at the negedge right after the updating edge.
  task automatic tick();
    @(negedge clk);
    HCount = 10'd0;
    VCount = 10'd480;
    @(negedge clk);
    HCount = 10'd100;
    VCount = 10'd100;
  endtask

  task automatic press(input int nn, input int np, input bit to_auto);
    int n;
    n = (nn > np) ? nn : np;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (to_auto) begin a_next = (i < nn); a_pause = (i < np); end
      else begin btn_next = (i < nn); btn_pause = (i < np); end
      idle(3);
      a_next = 1'b0; a_pause = 1'b0; btn_next = 1'b0; btn_pause = 1'b0;
      idle(3);
    end
    idle(2);
  endtask

  initial begin
    vt[0]  = '{0, 0,   2, 0, 304, 224, 1};
    vt[1]  = '{0, 1,   1, 0, 304, 224, 1};
    vt[2]  = '{1, 0,   0, 0, 304, 224, 1};
    vt[3]  = '{0, 0,   1, 0, 304, 224, 0};
    vt[4]  = '{0, 0,   1, 0, 306, 226, 0};
    vt[5]  = '{0, 0, 150, 0, 606, 370, 0};
    vt[6]  = '{0, 0,   1, 0, 608, 368, 0};
    vt[7]  = '{0, 0,   1, 0, 606, 366, 0};
    vt[8]  = '{0, 1,   1, 0, 606, 366, 0};
    vt[9]  = '{0, 0,   3, 0, 606, 366, 0};
    vt[10] = '{1, 0,   1, 1, 606, 366, 0};
    vt[11] = '{0, 1,   1, 1, 606, 366, 0};
    vt[12] = '{0, 0,   1, 1, 604, 364, 0};
    vt[13] = '{3, 0,   1, 2, 602, 362, 0};
    vt[14] = '{1, 1,   1, 3, 602, 362, 0};
    vt[15] = '{0, 1,   1, 3, 602, 362, 0};
    vt[16] = '{0, 0, 180, 3, 242,   2, 0};
    vt[17] = '{0, 0,   1, 3, 240,   0, 0};
    vt[18] = '{0, 0,   1, 3, 238,   2, 0};
    vt[19] = '{0, 0, 118, 3,   2, 238, 0};
    vt[20] = '{0, 0,   1, 3,   0, 240, 0};
    vt[21] = '{0, 0,   1, 3,   2, 242, 0};
    vt[22] = '{1, 0,   1, 0,   4, 244, 0};

    rst = 1'b0; HCount = 10'd100; VCount = 10'd100;
    btn_next = 1'b0; btn_pause = 1'b0; a_next = 1'b0; a_pause = 1'b0;
    idle(4);
    check("rst.fig_sel", fig_sel, 0);
    check("rst.fig_x", fig_x, 304);
    check("rst.fig_y", fig_y, 224);
    check("rst.blank", blank, 1);
    check("rst.frame_tick", frame_tick, 0);
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      press(vt[i].nn, vt[i].np, 1'b0);
      for (int t = 0; t < vt[i].nt; t++) tick();
      check($sformatf("vec%0d.fig_sel", i), fig_sel, vt[i].sel);
      check($sformatf("vec%0d.fig_x", i), fig_x, vt[i].x);
      check($sformatf("vec%0d.fig_y", i), fig_y, vt[i].y);
      check($sformatf("vec%0d.blank", i), blank, vt[i].blk);
    end

    // frame_tick lasts exactly one clock; this tick moves to x=6,y=246
    tick();
    check("tick.high", frame_tick, 1);
    check("tick.x", fig_x, 6);
    idle(1);
    check("tick.low", frame_tick, 0);

    // Reset while paused with a queued next request
    press(0, 1, 1'b0);
    tick();
    check("pause.x", fig_x, 6);
    press(1, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst.fig_sel", fig_sel, 0);
    check("midrst.fig_x", fig_x, 304);
    check("midrst.fig_y", fig_y, 224);
    check("midrst.blank", blank, 1);
    check("midrst.frame_tick", frame_tick, 0);
    tick();
    tick();
    check("midrst.discard.blank", blank, 1);
    check("midrst.discard.fig_sel", fig_sel, 0);

    // Edge reaching the pending flag on the tick edge waits one frame
    @(negedge clk);
    btn_next = 1'b1;
    @(negedge clk);
    @(negedge clk);
    HCount = 10'd0; VCount = 10'd480;
    @(negedge clk);
    HCount = 10'd100; VCount = 10'd100;
    check("coinc.frame_tick", frame_tick, 1);
    check("coinc.blank_held", blank, 1);
    btn_next = 1'b0;
    idle(3);
    tick();
    check("coinc.served.blank", blank, 0);
    check("coinc.served.fig_sel", fig_sel, 0);
    check("coinc.served.fig_x", fig_x, 304);

    // Auto-advance instance with HOLD_FRAMES=4
    press(1, 0, 1'b1);
    tick();
    check("auto.start.blank", a_blank, 0);
    check("auto.start.frame_tick", a_tick, 1);
    check("auto.start.fig_x", a_x, 304);
    check("auto.start.fig_y", a_y, 224);
    repeat (4) tick();
`ifdef FIGSEQ_AUTO_ADVANCE_EN
    check("auto.t4.fig_sel", a_sel, 1);
`else
    check("auto.t4.fig_sel", a_sel, 0);
`endif
    repeat (4) tick();
`ifdef FIGSEQ_AUTO_ADVANCE_EN
    check("auto.t8.fig_sel", a_sel, 2);
`else
    check("auto.t8.fig_sel", a_sel, 0);
`endif
    repeat (8) tick();
    check("auto.t16.fig_sel", a_sel, 0);
    check("auto.t16.fig_x", a_x, 336);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
